// File: rtl/rotating_patch_mem_if.sv
// rotating_patch_mem_if: write/read/control bundle for the rotating patch store.
interface rotating_patch_mem_if #(
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 4,
    parameter int PATCH_W = 2
);
    logic                      wr_en;
    logic [PATCH_W-1:0]        wr_patch;
    logic [ADDR_W-1:0]         wr_addr;
    logic signed [DATA_W-1:0]  wr_data;
    logic                      rd_en;
    logic [PATCH_W-1:0]        rd_patch;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0]  rd_data;
    logic                      rd_valid;
    logic                      rotate;
    logic                      clear_req;
    logic                      busy;

    modport master (
        output wr_en, wr_patch, wr_addr, wr_data,
        output rd_en, rd_patch, rd_addr, rotate, clear_req,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_patch, wr_addr, wr_data,
        input  rd_en, rd_patch, rd_addr, rotate, clear_req,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/rotating_patch_mem.sv
// rotating_patch_mem: NUM_PATCH-patch store with logical role rotation and a zero-fill sequencer.
// Define ROTPATCH_RDW_BYPASS_EN to forward same-cycle write data to a colliding read.
module rotating_patch_mem #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 4,
    parameter int NUM_PATCH = 3,
    parameter int PATCH_W   = 2
) (
    input logic                   clk,
    input logic                   reset,
    rotating_patch_mem_if.slave   bus
);
    localparam int IDX_W = PATCH_W + ADDR_W;
    localparam int DEPTH = NUM_PATCH << ADDR_W;
    localparam logic [PATCH_W:0]   NP        = (PATCH_W+1)'(NUM_PATCH);
    localparam logic [PATCH_W-1:0] LAST_BASE = PATCH_W'(NUM_PATCH - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   r_state;
    logic [PATCH_W-1:0]       r_base;
    logic [IDX_W-1:0]         r_cnt;
    logic                     r_busy;
    logic                     r_rd_valid;
    logic signed [DATA_W-1:0] r_rd_data;
    logic signed [DATA_W-1:0] r_mem [DEPTH];

    logic                     w_idle;
    logic [PATCH_W:0]         w_wr_sum;
    logic [PATCH_W:0]         w_rd_sum;
    logic                     w_wr_ok;
    logic                     w_rd_ok;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [IDX_W-1:0]         w_rd_idx;
    logic                     w_user_we;
    logic                     w_we;
    logic [IDX_W-1:0]         w_mem_idx;
    logic signed [DATA_W-1:0] w_mem_data;
    logic signed [DATA_W-1:0] w_rd_word;

    // Both operands are < NUM_PATCH for valid patches, so one conditional subtract is a full mod.
    always_comb begin
        w_idle     = r_state == IDLE;
        w_wr_sum   = {1'b0, bus.wr_patch} + {1'b0, r_base};
        w_rd_sum   = {1'b0, bus.rd_patch} + {1'b0, r_base};
        w_wr_ok    = {1'b0, bus.wr_patch} < NP;
        w_rd_ok    = {1'b0, bus.rd_patch} < NP;
        w_wr_idx   = {PATCH_W'(w_wr_sum >= NP ? w_wr_sum - NP : w_wr_sum), bus.wr_addr};
        w_rd_idx   = {PATCH_W'(w_rd_sum >= NP ? w_rd_sum - NP : w_rd_sum), bus.rd_addr};
        w_user_we  = w_idle && bus.wr_en && w_wr_ok;
        w_we       = !w_idle || w_user_we;
        w_mem_idx  = w_idle ? w_wr_idx : r_cnt;
        w_mem_data = w_idle ? bus.wr_data : '0;
`ifdef ROTPATCH_RDW_BYPASS_EN
        w_rd_word  = (w_user_we && w_wr_idx == w_rd_idx) ? bus.wr_data : r_mem[w_rd_idx];
`else
        w_rd_word  = r_mem[w_rd_idx];
`endif
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_mem_idx] <= w_mem_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_idle && bus.rd_en;
            if (w_idle && bus.rd_en)
                r_rd_data <= w_rd_ok ? w_rd_word : '0;
            if (w_idle) begin
                if (bus.clear_req) begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end else if (bus.rotate) begin
                    r_base  <= r_base == LAST_BASE ? '0 : r_base + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_base  <= '0;
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_rotating_patch_mem.sv
// tb_rotating_patch_mem: directed plan plus random traffic against a word-array reference model.
module tb_rotating_patch_mem;
    localparam int NP    = 3;
    localparam int PSZ   = 16;
    localparam int DEPTH = NP * PSZ;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    rotating_patch_mem_if #(.DATA_W(18), .ADDR_W(4), .PATCH_W(2)) bus ();

    rotating_patch_mem #(.DATA_W(18), .ADDR_W(4), .NUM_PATCH(NP), .PATCH_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: logical-to-physical offset, remaining clear cycles, word contents.
    int                 m_base;
    int                 m_busy_left;
    int                 m_clr_idx;
    logic signed [17:0] m_mem [DEPTH];
    bit                 m_known [DEPTH];
    logic signed [17:0] exp_data;
    bit                 exp_known;
    bit                 exp_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_base      = 0;
        m_busy_left = 0;
        exp_valid   = 0;
        exp_data    = 0;
        exp_known   = 1;
    endtask

    task automatic model_edge();
        int wi;
        int ri;
        bit wok;
        if (m_busy_left > 0) begin
            m_mem[m_clr_idx]   = 0;
            m_known[m_clr_idx] = 1;
            m_clr_idx++;
            m_busy_left--;
            if (m_busy_left == 0) m_base = 0;
            exp_valid = 0;
        end else begin
            wok = int'(bus.wr_patch) < NP;
            wi  = ((int'(bus.wr_patch) + m_base) % NP) * PSZ + int'(bus.wr_addr);
            exp_valid = bus.rd_en;
            if (bus.rd_en) begin
                if (int'(bus.rd_patch) >= NP) begin
                    exp_data  = 0;
                    exp_known = 1;
                end else begin
                    ri        = ((int'(bus.rd_patch) + m_base) % NP) * PSZ + int'(bus.rd_addr);
                    exp_data  = m_mem[ri];
                    exp_known = m_known[ri];
`ifdef ROTPATCH_RDW_BYPASS_EN
                    if (bus.wr_en && wok && wi == ri) begin
                        exp_data  = bus.wr_data;
                        exp_known = 1;
                    end
`endif
                end
            end
            if (bus.wr_en && wok) begin
                m_mem[wi]   = bus.wr_data;
                m_known[wi] = 1;
            end
            if (bus.clear_req) begin
                m_busy_left = DEPTH;
                m_clr_idx   = 0;
            end else if (bus.rotate) begin
                m_base = (m_base + 1) % NP;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(bus.busy), 32'(m_busy_left > 0));
        chk("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
        if (exp_known) chk("rd_data", 32'(bus.rd_data), 32'(exp_data));
    endtask

    task automatic cyc(input bit we = 0, input int wp = 0, input int wa = 0, input int wd = 0,
                       input bit re = 0, input int rp = 0, input int ra = 0,
                       input bit rot = 0, input bit clr = 0);
        bus.wr_en     = we;
        bus.wr_patch  = 2'(wp);
        bus.wr_addr   = 4'(wa);
        bus.wr_data   = 18'(wd);
        bus.rd_en     = re;
        bus.rd_patch  = 2'(rp);
        bus.rd_addr   = 4'(ra);
        bus.rotate    = rot;
        bus.clear_req = clr;
        step();
    endtask

    task automatic rand_cyc(input bit allow_clr);
        cyc(.we($urandom_range(0, 1)), .wp($urandom_range(0, 3)), .wa($urandom_range(0, 15)),
            .wd(int'($urandom)), .re($urandom_range(0, 1)), .rp($urandom_range(0, 3)),
            .ra($urandom_range(0, 15)), .rot($urandom_range(0, 3) == 0),
            .clr(allow_clr && $urandom_range(0, 79) == 0));
    endtask

    task automatic wait_clear_done(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            cyc(.we($urandom_range(0, 1)), .wp($urandom_range(0, 2)), .wa($urandom_range(0, 15)),
                .wd(int'($urandom)), .re($urandom_range(0, 1)), .rp($urandom_range(0, 2)),
                .ra($urandom_range(0, 15)), .rot($urandom_range(0, 1)), .clr($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        model_reset();
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 0);
        chk("reset_rd_data", 32'(bus.rd_data), 0);
        reset = 1'b0;

        cyc(.clr(1));
        wait_clear_done(n);
        chk("init_clear_len", n, DEPTH);

        // Plan 1: basic write then read.
        cyc(.we(1), .wp(1), .wa(3), .wd(5));
        cyc(.re(1), .rp(1), .ra(3));
        chk("t1_data", 32'(bus.rd_data), 5);
        chk("t1_valid", 32'(bus.rd_valid), 1);

        // Plan 2: next becomes curr after a rotate; three rotates wrap back.
        cyc(.we(1), .wp(2), .wa(0), .wd(-7));
        cyc(.rot(1));
        cyc(.re(1), .rp(1), .ra(0));
        chk("t2_rot1", 32'(bus.rd_data), -7);
        cyc(.rot(1));
        cyc(.rot(1));
        cyc(.re(1), .rp(2), .ra(0));
        chk("t2_wrap", 32'(bus.rd_data), -7);

        // Plan 3: a read in the rotate cycle still uses the old mapping.
        cyc(.we(1), .wp(0), .wa(9), .wd(100));
        cyc(.re(1), .rp(0), .ra(9), .rot(1));
        chk("t3_old_map", 32'(bus.rd_data), 100);
        cyc(.re(1), .rp(0), .ra(9));
        chk("t3_new_map", 32'(bus.rd_data), 0);
        cyc();

        // Plan 4: fill with nonzero data, clear, confirm length and zeroed contents.
        for (int p = 0; p < NP; p++)
            for (int a = 0; a < PSZ; a++)
                cyc(.we(1), .wp(p), .wa(a), .wd($urandom_range(1, 1000)));
        cyc(.clr(1), .rot(1));
        wait_clear_done(n);
        chk("t4_busy_len", n, DEPTH);
        for (int p = 0; p < NP; p++)
            for (int a = 0; a < PSZ; a++) begin
                cyc(.re(1), .rp(p), .ra(a));
                chk("t4_zero", 32'(bus.rd_data), 0);
            end
        cyc(.we(1), .wp(1), .wa(14), .wd(77));

        // Plan 5: read-during-write to the same word.
        cyc(.we(1), .wp(1), .wa(5), .wd(123));
        cyc(.we(1), .wp(1), .wa(5), .wd(18'h1FFFF), .re(1), .rp(1), .ra(5));
`ifdef ROTPATCH_RDW_BYPASS_EN
        chk("t5_rdw", 32'(bus.rd_data), 32'h1FFFF);
`else
        chk("t5_rdw", 32'(bus.rd_data), 123);
`endif
        cyc(.re(1), .rp(1), .ra(5));
        chk("t5_after", 32'(bus.rd_data), 32'h1FFFF);

        // Plan 6: reset 20 cycles into a clear; word 30 survives, invalid patch reads zero.
        cyc(.clr(1), .re(1), .rp(2), .ra(1));
        for (int i = 0; i < 19; i++) cyc();
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_rd_valid", 32'(bus.rd_valid), 0);
        reset = 1'b0;
        cyc(.re(1), .rp(3), .ra(0));
        chk("t6_bad_patch_data", 32'(bus.rd_data), 0);
        chk("t6_bad_patch_valid", 32'(bus.rd_valid), 1);
        cyc(.re(1), .rp(1), .ra(14));
        chk("t6_word30", 32'(bus.rd_data), 77);
        cyc(.re(1), .rp(0), .ra(3));
        chk("t6_word3", 32'(bus.rd_data), 0);

        // Random traffic against the model, including occasional clears.
        for (int i = 0; i < 400; i++) rand_cyc(1'b1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rotating_patch_mem.md
Name: rotating_patch_mem

Overview:
- Parametrised successor to the team's fixed three-patch u0/u1/u2 MLAB store for the wave-equation node.
- Holds NUM_PATCH patches of 2^ADDR_W signed words, with a separate read port and write port.
- Callers address patches logically (0=prev, 1=curr, 2=next). A one-cycle rotate pulse remaps roles at each time step, so no data is copied.
- A built-in clear sequencer zeroes the whole array before a new simulation.

Parameters:
DATA_W, 18, word width (signed)
ADDR_W, 4, in-patch address bits; patch size = 2^ADDR_W
NUM_PATCH, 3, number of patches (2..4)
PATCH_W, 2, patch-index width; must satisfy 2^PATCH_W >= NUM_PATCH

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
wr_en  in  1  write strobe
wr_patch  in  PATCH_W  logical patch for write
wr_addr  in  ADDR_W  in-patch write address
wr_data  in  DATA_W  signed write data
rd_en  in  1  read strobe
rd_patch  in  PATCH_W  logical patch for read
rd_addr  in  ADDR_W  in-patch read address
rd_data  out  DATA_W  signed registered read data
rd_valid  out  1  rd_data valid this cycle
rotate  in  1  time-step pulse; advances role mapping
clear_req  in  1  start zero-fill of all patches
busy  out  1  clear in progress

Behaviour:
- Reset state: rd_data=0, rd_valid=0, busy=0, base=0, FSM=IDLE. Array contents are not reset; they are undefined until written or cleared.
- Mapping: phys(l) = (l + base) mod NUM_PATCH.
  - Physical word index = phys*2^ADDR_W + addr.
  - Logical patch >= NUM_PATCH: the write is dropped; the read returns rd_data=0 with rd_valid=1.
- Rotate: on a rotate cycle, base <= (base+1) mod NUM_PATCH, so old curr becomes prev and old next becomes curr.
  - Reads and writes issued in the rotate cycle use the old mapping. The new mapping applies from the next cycle.
  - Wrap: with base=NUM_PATCH-1, rotate sets base=0.
- Read latency is 1 cycle. rd_en in cycle t gives rd_data and rd_valid=1 in cycle t+1.
  - When rd_en=0, rd_valid=0 the next cycle and rd_data holds its last value.
- Write: committed at the clock edge when wr_en=1 and FSM=IDLE.
- Read-during-write to the same physical word in the same cycle: behaviour is set by the optional feature below. Different words are independent.
- FSM states:
  - IDLE --clear_req--> CLEAR: clear counter=0, busy=1 from the next cycle.
  - CLEAR: writes 0 to word[counter], counter++. After word NUM_PATCH*2^ADDR_W-1, return to IDLE. base is also reset to 0 on that final cycle.
  - busy is high for exactly NUM_PATCH*2^ADDR_W cycles (48 at defaults).
- While busy:
  - wr_en is ignored.
  - rd_en is ignored and rd_valid=0.
  - rotate and clear_req are ignored.
- clear_req in the same cycle as rotate while IDLE: clear wins and the rotate is dropped.
- reset asserted mid-CLEAR: return to IDLE at once, busy=0; the array is left partially cleared.
- Arithmetic: address sums are unsigned; no overflow, because the physical index is < NUM_PATCH*2^ADDR_W by construction.

Optional Feature:
- Macro ROTPATCH_RDW_BYPASS_EN.
- Defined: on a same-cycle read and write to the same physical word, rd_data the next cycle equals wr_data (new data forwarded).
- Undefined: rd_data returns the old stored word. This is the MLAB no_rw_check-compatible behaviour, and the array may be inferred as MLAB.

Test Plan:
1. Reset, then write 18'sd5 to logical 1 addr 3; read logical 1 addr 3 -> next cycle rd_data=5, rd_valid=1.
2. Write -7 to (2,0), pulse rotate, read (1,0) -> -7. Pulse rotate twice more, read (2,0) -> -7 (wrap, base=0).
3. Write 100 to (0,9); in one cycle assert rotate and read (0,9) -> 100 (old mapping). Read (0,9) again next cycle -> a different physical word, not 100.
4. Fill words with nonzero values, pulse clear_req:
   - busy=1 for exactly 48 cycles, and wr_en/rd_en are ignored during that time.
   - Afterwards all 48 reads return 0 and base=0.
5. Write 0x1FFFF to (1,5) while reading (1,5) in the same cycle -> old value without ROTPATCH_RDW_BYPASS_EN, 0x1FFFF with it.
6. Assert reset at clear cycle 20 -> busy=0 immediately, rd_valid=0; word 30 keeps its prior value. Read (3,0) -> rd_data=0, rd_valid=1.
